surf_calc_sequencer: RTL and testbench
======================================

# surf_calc_sequencer

Controller for the plane surface calculator. It buffers one plane's worth of radius samples from an upstream stream, then replays them to the calculator as one contiguous enable burst. It captures the resulting plane surface and presents it downstream with a valid/ready handshake, along with a running volume sum over a frame of `N_PLANES` planes. The block sits between the radius acquisition path and the calculator, and owns the calculator's `en`/`rst`/`radius` inputs exclusively.

## Interface
- `N_SAMPLES`, 64: radius samples per plane; equals the calculator's integration window, range 2..256.
- `N_PLANES`, 16: planes per frame, range 1..65535.
- `SETTLE`, 4: idle cycles after a burst before `calc_surf` is sampled, minimum 3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous abort; returns the block to the state it has after reset.
- `s_valid` in 1: upstream radius valid.
- `s_ready` out 1: upstream ready.
- `s_radius` in 16: radius sample, unsigned.
- `calc_en` out 1: calculator enable.
- `calc_rst` out 1: calculator synchronous reset.
- `calc_radius` out 16: radius driven to the calculator.
- `calc_surf` in 32: calculator surface result.
- `m_valid` out 1: result valid.
- `m_ready` in 1: downstream ready.
- `m_surf` out 32: plane surface.
- `m_vol` out 48: frame volume sum including this plane.
- `m_plane` out 16: plane index within the frame, 0-based.
- `m_last` out 1: this is the last plane of the frame.
- `busy` out 1: the state is not LOAD, or the load counter is non-zero.

## Operation
- **INIT** (1 cycle): `calc_rst`=1, `calc_en`=0. Then go to LOAD.
- **LOAD**: `s_ready`=1. Each `s_valid&&s_ready` writes `buf[ld_cnt]` and increments `ld_cnt`. When sample `N_SAMPLES-1` is accepted, go to BURST and clear `ld_cnt`.
- **BURST**: `calc_en`=1 for exactly `N_SAMPLES` consecutive cycles. On burst cycle k, `calc_radius`=`buf[k]`. `s_ready`=0. Then go to DRAIN.
- **DRAIN**: `calc_en`=0 for `SETTLE` cycles. Then go to CAPTURE.
- **CAPTURE**: if the output register is empty, or `m_ready` is high this cycle:
  - load `m_surf`=`calc_surf`;
  - set `m_vol`=`vol+calc_surf`, wrapping modulo 2^48;
  - set `m_plane`=`plane_cnt` and `m_last`=(`plane_cnt`==`N_PLANES-1`);
  - set `m_valid`=1 and go to LOAD.
  
  Otherwise stay in CAPTURE; `calc_surf` is held because `calc_en` stays low.
- Frame accounting at capture:
  - `vol` gets the new sum, or 0 when `m_last`.
  - `plane_cnt` increments, or wraps to 0 when `m_last`.
- The output register clears when `m_valid&&m_ready`, unless it is reloaded in the same cycle.
- LOAD of the next plane may overlap a pending, unaccepted result.
- `calc_radius` is 0 whenever `calc_en`=0.

## Timing
- Reset values:
  - state INIT; `s_ready`=0, `calc_en`=0, `calc_rst`=1, `calc_radius`=0;
  - `m_valid`=0, `m_surf`=0, `m_vol`=0, `m_plane`=0, `m_last`=0, `busy`=1;
  - all counters and `vol` 0.
- `calc_rst` is high while `rst` is asserted, through the INIT cycle, and is combinational from the state register.
- Per-plane minimum period is `N_SAMPLES` (load) + `N_SAMPLES` (burst) + `SETTLE` + 1 cycles, with zero stalls.
- The first BURST cycle follows the cycle that accepted the last sample.
- The `m_valid` rise follows the CAPTURE cycle.
- `calc_en` never toggles mid-burst. Consecutive bursts are separated by at least `SETTLE`+`N_SAMPLES`+1 low cycles.
- `flush` in any state:
  - next state INIT;
  - `m_valid`, `vol`, `plane_cnt` and `ld_cnt` are cleared;
  - any partially loaded samples are discarded.
  
  `flush` takes priority over every handshake in the same cycle.
- `s_valid` during a non-LOAD state is ignored, and the sample is not consumed.
- `rst` asserted mid-burst drops `calc_en` immediately, asynchronously via the state register.

## Structure
- Package `surf_seq_pkg`:
  - `state_t` enum (INIT, LOAD, BURST, DRAIN, CAPTURE);
  - width constants `RADIUS_W`=16, `SURF_W`=32, `VOL_W`=48.
- Sub-module `radius_buf`: single-clock, 1-write/1-read, `N_SAMPLES`x16 register file with synchronous write and combinational read. It has no reset because contents are don't-care until written.
- The sequencer holds the FSM, the counters (`ld_cnt`, `burst_cnt`, `settle_cnt`, `plane_cnt`), and the output register.

## Test plan
- The bench uses a calculator stub whose `calc_surf` equals the sum of the radii seen during the last `calc_en` burst, valid 2 cycles after `en` falls.
- Reset, then 64 samples of value 10 with `m_ready`=1 -> `calc_en` is high for exactly 64 cycles; `m_surf`=640, `m_vol`=640, `m_plane`=0, `m_last`=0.
- `N_PLANES`=2, planes ramp 0..63 then all 1 -> `m_surf`=2016 then 64. The second result has `m_vol`=2080 and `m_last`=1. A third plane of all 2 gives `m_vol`=128 and `m_plane`=0.
- `s_valid` toggled randomly at 50% -> the burst is still 64 contiguous `calc_en` cycles and the result is unchanged.
- `m_ready`=0 for 300 cycles across two planes -> the first result is held stable and the second plane is loaded but waits in CAPTURE. No result is lost; results are in order after `m_ready`=1.
- `flush` at burst cycle 20 -> `calc_en` drops next cycle and `calc_rst` pulses. The next full plane of 5s yields `m_surf`=320, `m_plane`=0, `m_vol`=320.
- Async `rst` mid-LOAD after 30 samples -> outputs take their reset values without a clock edge; a following full plane behaves as in the first scenario.

Source files
------------

// File: rtl/surf_seq_pkg.sv
// Shared types and widths for the plane surface calculator sequencer.
package surf_seq_pkg;
   localparam int RADIUS_W = 16;
   localparam int SURF_W   = 32;
   localparam int VOL_W    = 48;

   typedef enum logic [2:0] {
      INIT,
      LOAD,
      BURST,
      DRAIN,
      CAPTURE
   } state_t;
endpackage

// File: rtl/surf_calc_sequencer_if.sv
// Upstream radius stream and downstream result handshake bundle.
interface surf_calc_sequencer_if;
   import surf_seq_pkg::*;

   logic                s_valid;
   logic                s_ready;
   logic [RADIUS_W-1:0] s_radius;
   logic                m_valid;
   logic                m_ready;
   logic [SURF_W-1:0]   m_surf;
   logic [VOL_W-1:0]    m_vol;
   logic [15:0]         m_plane;
   logic                m_last;

   modport master (
      output s_valid, s_radius, m_ready,
      input  s_ready, m_valid, m_surf, m_vol, m_plane, m_last
   );

   modport slave (
      input  s_valid, s_radius, m_ready,
      output s_ready, m_valid, m_surf, m_vol, m_plane, m_last
   );
endinterface

// File: rtl/surf_calc_sequencer_radius_buf.sv
// One plane of radius samples: sync write, combinational read, no reset.
module radius_buf #(
   parameter  int DEPTH = 64,
   parameter  int W     = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/surf_calc_sequencer.sv
// Buffers a plane of radii, replays them as one enable burst to the
// calculator, then captures the surface with running frame volume.
module surf_calc_sequencer
   import surf_seq_pkg::*;
#(
   parameter int N_SAMPLES = 64,
   parameter int N_PLANES  = 16,
   parameter int SETTLE    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   surf_calc_sequencer_if.slave bus,
   output logic                calc_en,
   output logic                calc_rst,
   output logic [RADIUS_W-1:0] calc_radius,
   input  logic [SURF_W-1:0]   calc_surf,
   output logic                busy
);
   localparam int CW = $clog2(N_SAMPLES);
   localparam int SW = $clog2(SETTLE);
   localparam logic [CW-1:0] LAST_S = CW'(N_SAMPLES - 1);
   localparam logic [SW-1:0] LAST_D = SW'(SETTLE - 1);
   localparam logic [15:0]   LAST_P = 16'(N_PLANES - 1);

   state_t              state;
   state_t              state_nx;
   logic [CW-1:0]       ld_cnt;
   logic [CW-1:0]       burst_cnt;
   logic [SW-1:0]       settle_cnt;
   logic [15:0]         plane_cnt;
   logic [VOL_W-1:0]    vol;
   logic [VOL_W-1:0]    vol_sum;
   logic [RADIUS_W-1:0] rd_data;
   logic                s_fire;
   logic                cap;
   logic                last_p;

   assign s_fire  = bus.s_valid && bus.s_ready;
   assign cap     = (state == CAPTURE) && (!bus.m_valid || bus.m_ready);
   assign vol_sum = vol + VOL_W'(calc_surf);
   assign last_p  = (plane_cnt == LAST_P);
   assign busy    = (state != LOAD) || (ld_cnt != '0);

   radius_buf #(
      .DEPTH (N_SAMPLES),
      .W     (RADIUS_W)
   ) u_buf (
      .clk   (clk),
      .we    (s_fire),
      .waddr (ld_cnt),
      .wdata (bus.s_radius),
      .raddr (burst_cnt),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         INIT:    state_nx = LOAD;
         LOAD:    if (s_fire && ld_cnt == LAST_S) state_nx = BURST;
         BURST:   if (burst_cnt == LAST_S) state_nx = DRAIN;
         DRAIN:   if (settle_cnt == LAST_D) state_nx = CAPTURE;
         CAPTURE: if (cap) state_nx = LOAD;
         default: state_nx = INIT;
      endcase
      if (flush) state_nx = INIT;
   end

   // flush also gates s_ready so an abort never consumes a sample
   always_comb begin
      bus.s_ready = 1'b0;
      calc_en     = 1'b0;
      calc_rst    = 1'b0;
      calc_radius = '0;
      unique case (state)
         INIT:  calc_rst = 1'b1;
         LOAD:  bus.s_ready = !flush;
         BURST: begin
            calc_en     = 1'b1;
            calc_radius = rd_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_cnt     <= '0;
         burst_cnt  <= '0;
         settle_cnt <= '0;
      end else if (flush) begin
         ld_cnt     <= '0;
         burst_cnt  <= '0;
         settle_cnt <= '0;
      end else begin
         if (s_fire)
            ld_cnt <= (ld_cnt == LAST_S) ? '0 : ld_cnt + 1'b1;
         if (state == BURST)
            burst_cnt <= (burst_cnt == LAST_S) ? '0 : burst_cnt + 1'b1;
         if (state == DRAIN)
            settle_cnt <= (settle_cnt == LAST_D) ? '0 : settle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.m_valid <= 1'b0;
         bus.m_surf  <= '0;
         bus.m_vol   <= '0;
         bus.m_plane <= '0;
         bus.m_last  <= 1'b0;
         vol         <= '0;
         plane_cnt   <= '0;
      end else if (flush) begin
         bus.m_valid <= 1'b0;
         bus.m_surf  <= '0;
         bus.m_vol   <= '0;
         bus.m_plane <= '0;
         bus.m_last  <= 1'b0;
         vol         <= '0;
         plane_cnt   <= '0;
      end else if (cap) begin
         bus.m_valid <= 1'b1;
         bus.m_surf  <= calc_surf;
         bus.m_vol   <= vol_sum;
         bus.m_plane <= plane_cnt;
         bus.m_last  <= last_p;
         vol         <= last_p ? '0 : vol_sum;
         plane_cnt   <= last_p ? '0 : plane_cnt + 1'b1;
      end else if (bus.m_valid && bus.m_ready) begin
         bus.m_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_surf_calc_sequencer.sv
// Bench for surf_calc_sequencer: calculator stub, table vectors,
// corner sequences and a randomized run against a plane-level model.
module tb_surf_calc_sequencer;
   localparam int NS = 64;
   localparam int NP = 2;
   localparam int ST = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        calc_en;
   logic        calc_rst;
   logic [15:0] calc_radius;
   logic [31:0] calc_surf;
   logic        busy;

   surf_calc_sequencer_if bus ();

   surf_calc_sequencer #(
      .N_SAMPLES (NS),
      .N_PLANES  (NP),
      .SETTLE    (ST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus.slave),
      .calc_en     (calc_en),
      .calc_rst    (calc_rst),
      .calc_radius (calc_radius),
      .calc_surf   (calc_surf),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // calculator stub: sum of last burst, visible 2 cycles after en falls
   logic [31:0] acc;
   logic        en_q;
   logic        f1;
   always @(posedge clk) begin
      if (calc_rst) begin
         acc       <= 0;
         en_q      <= 0;
         f1        <= 0;
         calc_surf <= 0;
      end else begin
         en_q <= calc_en;
         f1   <= en_q && !calc_en;
         if (calc_en) acc <= en_q ? acc + calc_radius : {16'd0, calc_radius};
         if (f1) calc_surf <= acc;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // plane-level reference model
   typedef struct {
      logic [31:0] surf;
      logic [47:0] vol;
      logic [15:0] plane;
      logic        last;
   } res_t;

   res_t            expq[$];
   res_t            mon_e;
   longint unsigned cur_sum;
   int              cur_n;
   logic [47:0]     mvol;
   int              mplane;
   int              n_res = 0;

   function automatic void model_clear();
      cur_sum = 0;
      cur_n   = 0;
      mvol    = 0;
      mplane  = 0;
      expq.delete();
   endfunction

   function automatic void model_push(logic [15:0] r);
      res_t e;
      cur_sum += r;
      cur_n++;
      if (cur_n == NS) begin
         e.surf  = cur_sum[31:0];
         e.vol   = mvol + {16'd0, e.surf};
         e.plane = 16'(mplane);
         e.last  = (mplane == NP - 1);
         expq.push_back(e);
         if (e.last) begin
            mvol   = 0;
            mplane = 0;
         end else begin
            mvol   = e.vol;
            mplane = mplane + 1;
         end
         cur_sum = 0;
         cur_n   = 0;
      end
   endfunction

   int run = 0;
   int gap = 0;
   bit aborted = 0;
   bit seen_burst = 0;

   always @(negedge clk) begin
      if (rst || flush) begin
         model_clear();
         aborted = 1;
      end else begin
         if (bus.s_valid && bus.s_ready) model_push(bus.s_radius);
         if (bus.m_valid && bus.m_ready) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: got surf %0d expected none",
                        bus.m_surf);
            end else begin
               mon_e = expq.pop_front();
               chk("res_surf", bus.m_surf, mon_e.surf);
               chk("res_vol", bus.m_vol, mon_e.vol);
               chk("res_plane", bus.m_plane, mon_e.plane);
               chk("res_last", bus.m_last, mon_e.last);
               n_res++;
            end
         end
      end
      if (calc_en) begin
         if (run == 0) begin
            if (seen_burst && !aborted)
               chk("burst_gap_ok", gap >= NS + ST + 1, 1);
            aborted = 0;
         end
         run++;
         gap = 0;
         seen_burst = 1;
      end else begin
         if (run > 0) begin
            if (!aborted) chk("burst_len", run, NS);
            run = 0;
         end
         gap++;
         chk("idle_radius_zero", calc_radius, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.s_valid = 0;
      flush = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   // mode 0 constant, 1 ramp, 2 random radii
   task automatic feed(int mode, int val, int cnt, int duty, bit rnd_ready);
      int   i = 0;
      int   guard = 0;
      bit   acc_s;
      logic [15:0] r;
      while (i < cnt && guard < 20000) begin
         r = (mode == 0) ? 16'(val) : (mode == 1) ? 16'(i) : 16'($urandom);
         bus.s_radius = r;
         bus.s_valid = ($urandom_range(99) < duty);
         if (rnd_ready) bus.m_ready = $urandom_range(1);
         @(negedge clk);
         acc_s = bus.s_valid && bus.s_ready;
         tick();
         if (acc_s) i++;
         guard++;
      end
      bus.s_valid = 0;
      if (i < cnt) chk("feed_timeout", i, cnt);
   endtask

   task automatic wait_valid(output bit ok);
      int g = 0;
      ok = 0;
      while (g < 2000) begin
         @(negedge clk);
         if (bus.m_valid) begin
            ok = 1;
            break;
         end
         g++;
      end
      if (!ok) chk("result_timeout", 0, 1);
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_s_ready"}, bus.s_ready, 0);
      chk({tag, "_calc_en"}, calc_en, 0);
      chk({tag, "_calc_rst"}, calc_rst, 1);
      chk({tag, "_calc_radius"}, calc_radius, 0);
      chk({tag, "_m_valid"}, bus.m_valid, 0);
      chk({tag, "_m_surf"}, bus.m_surf, 0);
      chk({tag, "_m_vol"}, bus.m_vol, 0);
      chk({tag, "_m_plane"}, bus.m_plane, 0);
      chk({tag, "_m_last"}, bus.m_last, 0);
      chk({tag, "_busy"}, busy, 1);
   endtask

   typedef struct {
      bit          pre_rst;
      int          mode;
      int          val;
      int          duty;
      logic [31:0] surf;
      logic [47:0] vol;
      logic [15:0] plane;
      logic        last;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int nb;
      int r0;
      tbl[0] = '{1'b1, 0, 10, 100, 32'd640, 48'd640, 16'd0, 1'b0};
      tbl[1] = '{1'b1, 1, 0, 100, 32'd2016, 48'd2016, 16'd0, 1'b0};
      tbl[2] = '{1'b0, 0, 1, 100, 32'd64, 48'd2080, 16'd1, 1'b1};
      tbl[3] = '{1'b0, 0, 2, 100, 32'd128, 48'd128, 16'd0, 1'b0};
      tbl[4] = '{1'b0, 0, 10, 50, 32'd640, 48'd768, 16'd1, 1'b1};

      bus.s_valid = 0;
      bus.s_radius = 0;
      bus.m_ready = 1;
      model_clear();
      #12;
      chk_reset_vals("reset");
      do_reset();

      for (int i = 0; i < 5; i++) begin
         if (tbl[i].pre_rst) do_reset();
         bus.m_ready = 1;
         feed(tbl[i].mode, tbl[i].val, NS, tbl[i].duty, 0);
         wait_valid(ok);
         if (ok) begin
            chk($sformatf("vec%0d_surf", i), bus.m_surf, tbl[i].surf);
            chk($sformatf("vec%0d_vol", i), bus.m_vol, tbl[i].vol);
            chk($sformatf("vec%0d_plane", i), bus.m_plane, tbl[i].plane);
            chk($sformatf("vec%0d_last", i), bus.m_last, tbl[i].last);
         end
         tick();
      end

      // downstream stalled across two planes
      do_reset();
      bus.m_ready = 0;
      feed(0, 3, NS, 100, 0);
      feed(0, 4, NS, 100, 0);
      repeat (120) begin
         @(negedge clk);
         chk("hold_stable", {bus.m_valid, bus.m_surf}, {1'b1, 32'd192});
         tick();
      end
      @(negedge clk);
      chk("hold_plane", bus.m_plane, 0);
      chk("hold_s_ready", bus.s_ready, 0);
      chk("hold_busy", busy, 1);
      tick();
      bus.m_ready = 1;
      @(negedge clk);
      chk("release_first", bus.m_surf, 192);
      tick();
      @(negedge clk);
      chk("release_second", {bus.m_valid, bus.m_surf}, {1'b1, 32'd256});
      chk("release_second_last", bus.m_last, 1);
      tick();
      @(negedge clk);
      chk("release_drained", bus.m_valid, 0);
      tick();

      // flush at burst cycle 20
      do_reset();
      bus.m_ready = 1;
      feed(0, 1, NS, 100, 0);
      wait_valid(ok);
      if (ok) chk("pre_flush_vol", bus.m_vol, 64);
      tick();
      feed(0, 7, NS, 100, 0);
      nb = 0;
      for (int g = 0; g < 500 && nb < 20; g++) begin
         @(negedge clk);
         if (calc_en) nb++;
         if (nb < 20) tick();
      end
      chk("flush_reached_cycle20", nb, 20);
      tick();
      flush = 1;
      @(negedge clk);
      chk("flush_cycle_en", calc_en, 1);
      tick();
      flush = 0;
      @(negedge clk);
      chk("flush_en_drop", calc_en, 0);
      chk("flush_calc_rst", calc_rst, 1);
      chk("flush_radius", calc_radius, 0);
      tick();
      @(negedge clk);
      chk("flush_rst_pulse_end", calc_rst, 0);
      chk("flush_load", bus.s_ready, 1);
      tick();
      feed(0, 5, NS, 100, 0);
      wait_valid(ok);
      if (ok) begin
         chk("post_flush_surf", bus.m_surf, 320);
         chk("post_flush_plane", bus.m_plane, 0);
         chk("post_flush_vol", bus.m_vol, 320);
         chk("post_flush_last", bus.m_last, 0);
      end
      tick();

      // async reset mid-LOAD with a pending result
      do_reset();
      bus.m_ready = 0;
      feed(0, 10, NS, 100, 0);
      wait_valid(ok);
      tick();
      feed(0, 9, 30, 100, 0);
      @(negedge clk);
      chk("pre_arst_valid", bus.m_valid, 1);
      chk("pre_arst_busy", busy, 1);
      #2;
      rst = 1;
      #1;
      chk_reset_vals("arst");
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      bus.m_ready = 1;
      feed(0, 10, NS, 100, 0);
      wait_valid(ok);
      if (ok) begin
         chk("post_arst_surf", bus.m_surf, 640);
         chk("post_arst_vol", bus.m_vol, 640);
         chk("post_arst_plane", bus.m_plane, 0);
         chk("post_arst_last", bus.m_last, 0);
      end
      tick();

      // randomized planes, stream gaps and downstream stalls
      do_reset();
      r0 = n_res;
      for (int p = 0; p < 30; p++) feed(2, 0, NS, 50, 1);
      bus.m_ready = 1;
      for (int g = 0; g < 2000 && (n_res - r0) < 30; g++) tick();
      chk("rand_result_count", n_res - r0, 30);
      chk("rand_queue_empty", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
